// File: rtl/wave_pkg.sv
// Shared types and helpers for the waveform capture sequencer.
// State encoding, frame geometry and sample format conversion.
package wave_pkg;

  typedef enum logic [1:0] {
    ARMED  = 2'd0,
    ACTIVE = 2'd1,
    WAIT   = 2'd2
  } state_t;

  localparam int SAMPLES_PER_FRAME = 256;
  localparam int RAM_ADDR_W = 9;

  // Signed sample MSB byte to unsigned display byte.
  function automatic logic [7:0] to_display(
    input logic [15:0] s
  );
    return {~s[15], s[14:8]};
  endfunction

endpackage

// File: rtl/dffr.sv
// Generic flop cell with synchronous active-high reset.
// Loads d when en is high.
module dffr #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Enabled register, cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else if (en) q <= d;
  end

endmodule

// File: rtl/wave_trigger_detect.sv
// Rising zero-crossing detector with a capture timeout.
// Flags are combinational; the caller registers its outputs.
module wave_trigger_detect #(
  parameter int TRIG_TIMEOUT = 1024,
  parameter int TO_W = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic armed,
  input  logic new_sample_ready,
  input  logic sample_neg,
  output logic trigger,
  output logic forced
);

  logic            prev_neg;
  logic [TO_W-1:0] tcnt;
  logic [TO_W-1:0] tcnt_d;
  logic            tcnt_en;
  logic            crossing;
  logic            expired;

  assign crossing = new_sample_ready & prev_neg & ~sample_neg;
  assign expired  = tcnt == TO_W'(TRIG_TIMEOUT - 1);
  assign trigger  = armed & crossing;
  assign forced   = armed & new_sample_ready & ~crossing & expired;

  // Counter holds at zero outside ARMED so each arming starts fresh.
  always_comb begin
    tcnt_en = 1'b0;
    tcnt_d  = '0;
    if (!armed || trigger || forced) begin
      tcnt_en = 1'b1;
    end else if (new_sample_ready) begin
      tcnt_en = 1'b1;
      tcnt_d  = tcnt + 1'b1;
    end
  end

  dffr #(.W(1)) u_prev_neg (
    .clk   (clk),
    .reset (reset),
    .en    (new_sample_ready),
    .d     (sample_neg),
    .q     (prev_neg)
  );

  dffr #(.W(TO_W)) u_tcnt (
    .clk   (clk),
    .reset (reset),
    .en    (tcnt_en),
    .d     (tcnt_d),
    .q     (tcnt)
  );

endmodule

// File: rtl/wave_capture.sv
// Captures 256-sample frames into the hidden half of a
// double-buffered RAM and swaps halves while the display idles.
module wave_capture
  import wave_pkg::*;
#(
  parameter int TRIG_TIMEOUT = 1024,
  parameter int TO_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  new_sample_ready,
  input  logic [15:0]           new_sample_in,
  input  logic                  wave_display_idle,
  output logic [RAM_ADDR_W-1:0] write_address,
  output logic                  write_enable,
  output logic [7:0]            write_sample,
  output logic                  read_index,
  output logic                  forced_trigger
);

  state_t     state;
  logic [7:0] count;
  logic       trigger;
  logic       forced;

  wave_trigger_detect #(
    .TRIG_TIMEOUT (TRIG_TIMEOUT),
    .TO_W         (TO_W)
  ) u_trig (
    .clk              (clk),
    .reset            (reset),
    .armed            (state == ARMED),
    .new_sample_ready (new_sample_ready),
    .sample_neg       (new_sample_in[15]),
    .trigger          (trigger),
    .forced           (forced)
  );

  // Capture FSM with registered RAM write port and buffer select.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ARMED;
      count          <= '0;
      write_enable   <= 1'b0;
      write_address  <= '0;
      write_sample   <= '0;
      read_index     <= 1'b0;
      forced_trigger <= 1'b0;
    end else begin
      write_enable   <= 1'b0;
      forced_trigger <= 1'b0;
      unique case (state)
        ARMED: begin
          if (trigger || forced) begin
            write_enable   <= 1'b1;
            write_address  <= {~read_index, 8'd0};
            write_sample   <= to_display(new_sample_in);
            forced_trigger <= forced;
            count          <= 8'd1;
            state          <= ACTIVE;
          end
        end
        ACTIVE: begin
          if (new_sample_ready) begin
            write_enable  <= 1'b1;
            write_address <= {~read_index, count};
            write_sample  <= to_display(new_sample_in);
            count         <= count + 8'd1;
            if (count == 8'(SAMPLES_PER_FRAME - 1)) begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (wave_display_idle) begin
            read_index <= ~read_index;
            state      <= ARMED;
          end
        end
        default: state <= ARMED;
      endcase
    end
  end

endmodule

// File: tb/tb_wave_capture.sv
// Directed self-checking bench for wave_capture.
// Runs with an 8-sample trigger timeout.
module tb_wave_capture;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        new_sample_ready = 1'b0;
  logic [15:0] new_sample_in = '0;
  logic        wave_display_idle = 1'b0;
  logic [8:0]  write_address;
  logic        write_enable;
  logic [7:0]  write_sample;
  logic        read_index;
  logic        forced_trigger;

  int total = 0;
  int bad = 0;

  typedef struct {
    logic [15:0] s;
    logic        we;
    logic [8:0]  addr;
    logic [7:0]  data;
    logic        frc;
  } vec_t;

  vec_t tbl [3];

  always #5 clk = ~clk;

  wave_capture #(
    .TRIG_TIMEOUT (8),
    .TO_W         (16)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .new_sample_ready  (new_sample_ready),
    .new_sample_in     (new_sample_in),
    .wave_display_idle (wave_display_idle),
    .write_address     (write_address),
    .write_enable      (write_enable),
    .write_sample      (write_sample),
    .read_index        (read_index),
    .forced_trigger    (forced_trigger)
  );

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [15:0] s);
    new_sample_in    = s;
    new_sample_ready = 1'b1;
    @(posedge clk);
    #1;
    new_sample_ready = 1'b0;
  endtask

  task automatic exp_write(input string nm,
                           input logic [8:0] a,
                           input logic [7:0] d,
                           input logic f);
    chk({nm, ".we"}, 32'(write_enable), 32'd1);
    chk({nm, ".addr"}, 32'(write_address), 32'(a));
    chk({nm, ".data"}, 32'(write_sample), 32'(d));
    chk({nm, ".frc"}, 32'(forced_trigger), 32'(f));
  endtask

  task automatic exp_none(input string nm);
    chk({nm, ".we"}, 32'(write_enable), 32'd0);
  endtask

  // Ramp k*256 for k=1..n, written at base+k; no tick after last.
  task automatic ramp(input logic [8:0] base,
                      input int n,
                      input bit idle_last);
    for (int k = 1; k <= n; k++) begin
      if (idle_last && k == n) wave_display_idle = 1'b1;
      strobe(16'(k * 256));
      exp_write($sformatf("ramp%0d", k),
                base + 9'(k), 8'(k) ^ 8'h80, 1'b0);
      chk($sformatf("ramp%0d.ri", k), 32'(read_index),
          32'(base[8] ? 1'b0 : 1'b1));
      if (k != n) begin
        tick();
        if (k % 32 == 0) exp_none($sformatf("gap%0d", k));
      end
    end
  endtask

  initial begin
    tbl[0] = '{16'hFFFB, 1'b0, 9'h000, 8'h00, 1'b0};
    tbl[1] = '{16'hFFFF, 1'b0, 9'h000, 8'h00, 1'b0};
    tbl[2] = '{16'h0003, 1'b1, 9'h100, 8'h80, 1'b0};

    tick();
    tick();
    reset = 1'b0;
    chk("rst.we", 32'(write_enable), 32'd0);
    chk("rst.addr", 32'(write_address), 32'd0);
    chk("rst.data", 32'(write_sample), 32'd0);
    chk("rst.ri", 32'(read_index), 32'd0);
    chk("rst.frc", 32'(forced_trigger), 32'd0);

    for (int i = 0; i < 3; i++) begin
      strobe(tbl[i].s);
      chk($sformatf("tbl%0d.we", i), 32'(write_enable),
          32'(tbl[i].we));
      if (tbl[i].we) begin
        chk($sformatf("tbl%0d.addr", i), 32'(write_address),
            32'(tbl[i].addr));
        chk($sformatf("tbl%0d.data", i), 32'(write_sample),
            32'(tbl[i].data));
        chk($sformatf("tbl%0d.frc", i), 32'(forced_trigger),
            32'(tbl[i].frc));
      end
      tick();
      chk($sformatf("tbl%0d.gap", i), 32'(write_enable), 32'd0);
    end

    ramp(9'h100, 255, 1'b0);
    tick();
    strobe(16'hFFFF);
    exp_none("wait_neg");
    tick();
    strobe(16'h0001);
    exp_none("wait_cross");
    tick();

    repeat (500) tick();
    chk("busy.ri", 32'(read_index), 32'd0);
    wave_display_idle = 1'b1;
    tick();
    chk("swap.ri", 32'(read_index), 32'd1);
    wave_display_idle = 1'b0;

    for (int i = 1; i <= 7; i++) begin
      strobe(16'd100);
      exp_none($sformatf("to%0d", i));
      chk($sformatf("to%0d.frc", i), 32'(forced_trigger), 32'd0);
      tick();
    end
    strobe(16'd100);
    exp_write("to8", 9'h000, 8'h80, 1'b1);
    tick();
    chk("to8.pulse", 32'(forced_trigger), 32'd0);
    exp_none("to8.gap");

    ramp(9'h000, 99, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort.we", 32'(write_enable), 32'd0);
    chk("abort.ri", 32'(read_index), 32'd0);

    strobe(16'hFFFF);
    exp_none("re_neg");
    tick();
    strobe(16'h0001);
    exp_write("re_cross", 9'h100, 8'h80, 1'b0);
    tick();

    ramp(9'h100, 255, 1'b1);
    chk("last.addr", 32'(write_address), 32'h1FF);
    tick();
    chk("late.ri", 32'(read_index), 32'd1);
    exp_none("late.we");
    wave_display_idle = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wave_capture.md
Name: wave_capture

Overview:
Sequencer for the double-buffered 2x256x8 sample RAM that the waveform display reads. It watches the audio sample stream and waits for a rising zero crossing, or forces a capture after a timeout. It then writes 256 consecutive samples into the half the display is not reading. When the display is idle, it swaps halves by toggling read_index.

Parameters:
TRIG_TIMEOUT, 1024, samples received in ARMED without a crossing before a capture is forced (range 2..65535)
TO_W, 16, width of the timeout counter (must hold TRIG_TIMEOUT-1)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
new_sample_ready  input  1  one-cycle strobe; new_sample_in valid this cycle
new_sample_in  input  16  signed two's-complement audio sample
wave_display_idle  input  1  high while the display is outside the visible region
write_address  output  9  RAM write address {~read_index, count[7:0]}
write_enable  output  1  RAM write strobe
write_sample  output  8  unsigned sample = {~new_sample_in[15], new_sample_in[14:8]}
read_index  output  1  RAM half the display reads; toggled only by this block
forced_trigger  output  1  one-cycle pulse when a capture starts by timeout rather than by a crossing

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: state=ARMED, count=0, timeout counter=0, prev_neg=0, write_enable=0, write_address=0, write_sample=0, read_index=0, forced_trigger=0.
- A reset in any state, including mid-capture, aborts the capture. A partially written half is left as is and read_index returns to 0.
- prev_neg register: loads new_sample_in[15] on every new_sample_ready, in all states.
- Crossing definition: new_sample_ready & prev_neg & ~new_sample_in[15], i.e. negative to non-negative.
- All outputs are registered. A write caused by a strobe in cycle N appears in cycle N+1 with write_enable=1 for exactly one cycle.
- State ARMED:
  - On a strobe with a crossing: go to ACTIVE. This crossing sample is written at count 0.
  - On a strobe with no crossing and timeout counter==TRIG_TIMEOUT-1: force the trigger. The sample is written at count 0, forced_trigger pulses in cycle N+1, and the state goes to ACTIVE.
  - Otherwise, on a strobe: increment the timeout counter.
  - The timeout counter clears on every entry to ARMED.
- State ACTIVE:
  - Each strobe writes one sample at {~read_index, count} and increments count.
  - The strobe that writes count=255 moves the state to WAIT and wraps count to 0.
  - Non-strobe cycles produce no write.
- State WAIT:
  - Samples are ignored; there are no writes.
  - On the first cycle in WAIT with wave_display_idle=1: toggle read_index and go to ARMED.
  - If idle is already high on the first WAIT cycle, the toggle happens then. That is one cycle after the 256th write is issued.
- read_index never changes in ARMED or ACTIVE, so the display never sees a half being written.
- The trigger sample (count 0) is written in the strobe's own cycle+1, the same as any other write. There is no extra latency on the first sample.
- Strobes arrive at most every other cycle. Behaviour under back-to-back strobes is still defined: each strobe produces one write.

Decomposition:
- Shared package (wave_pkg):
  - state encoding: ARMED=2'd0, ACTIVE=2'd1, WAIT=2'd2
  - SAMPLES_PER_FRAME=256
  - RAM_ADDR_W=9
  - conversion of the signed sample MSB byte to unsigned display format (MSB inverted)
- Registers use the existing dffr flop cell.
- One natural sub-module, wave_trigger_detect. It holds prev_neg and the timeout counter and outputs the trigger and forced flags. The FSM and address generation stay in wave_capture.

Test Plan:
- Reset then samples -5, -1, +3: +3 triggers. write_enable at strobe+1 with write_address=9'h100, write_sample=8'h80, forced_trigger=0.
- After a trigger, feed 255 more ramp samples 16'h0100*k (k=1..255). Addresses run 9'h101..9'h1FF with data {~MSB, bits14:8}. No write is issued for further strobes while in WAIT.
- In WAIT with wave_display_idle=0 for 500 cycles: read_index stays 0. Raise idle: read_index becomes 1 on the next edge, state returns to ARMED, and the next capture writes addresses 9'h000..9'h0FF.
- TRIG_TIMEOUT=8 with a constant +100 input: the 8th sample after entry to ARMED is written at address {~read_index, 8'h00} and forced_trigger pulses once.
- Assert reset after write 100 of a capture: the next cycle shows write_enable=0 and read_index=0. Samples -1, +1 then restart the capture at 9'h100.
- Simultaneous events: idle already high when the last write is issued gives a read_index toggle exactly 1 cycle later. A crossing arriving in WAIT does not trigger.
